// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and the default baud divisor,
// so transmitter and receiver agree on bit timing.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;
    localparam int unsigned UART_FIFO_DEPTH   = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty derive from the registered count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are log2(DEPTH) wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer FSM with a
// baud counter; txd is registered and frames run back-to-back while data waits.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_we,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state;
    uart_tx_state_t state_d;

    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [7:0]        shift_d;
    logic              txd_q;
    logic              txd_d;
    logic              pop;
    logic              baud_last;
    logic              bit_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_we),
        .wr_data (tx_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (tx_count)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_idx == BIT_LAST);
    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state != TX_IDLE) || !fifo_empty;
    assign txd       = txd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_last && bit_last) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    state_d = fifo_empty ? TX_IDLE : TX_START;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // txd is computed from the next state so the registered line changes on
    // the same edge as the state, giving the 2-cycle push-to-start latency.
    always_comb begin
        pop     = 1'b0;
        shift_d = shift;
        txd_d   = 1'b1;
        if ((state == TX_IDLE && !fifo_empty) ||
            (state == TX_STOP && baud_last && !fifo_empty)) begin
            pop     = 1'b1;
            shift_d = fifo_head;
        end else if (state == TX_DATA && baud_last) begin
            shift_d = {1'b0, shift[7:1]};
        end
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd_q    <= 1'b1;
        end else begin
            shift <= shift_d;
            txd_q <= txd_d;
            if (state == TX_IDLE || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state != TX_DATA) begin
                bit_idx <= '0;
            end else if (baud_last) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: frame-level model, mid-bit UART monitor,
// and directed scenarios with literal expectations.
module tb_uart_tx_buf;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_we = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic [2:0] tx_count;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    uart_tx_buf #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of waiting bytes plus elapsed time within the current frame.
    logic [7:0] mq[$];
    bit         m_act = 1'b0;
    int         m_el  = 0;
    logic [7:0] m_cur = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_el  = 0;
        end else begin : model_step
            bit acc;
            acc = tx_we && (mq.size() < D);
            if (m_act) begin
                m_el++;
                if (m_el == 10 * C) begin
                    if (mq.size() != 0) begin
                        m_cur = mq.pop_front();
                        m_el  = 0;
                    end else begin
                        m_act = 1'b0;
                    end
                end
            end else if (mq.size() != 0) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_el  = 0;
            end
            if (acc) mq.push_back(tx_data);
        end
    end

    function automatic logic model_txd();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_el / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    // Monitor: finds the start edge and samples each bit in its middle.
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] rxq[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        #2;
        chk("txd", txd, model_txd());
        chk("tx_count", tx_count, mq.size());
        chk("tx_ready", tx_ready, mq.size() != D);
        chk("tx_busy", tx_busy, m_act || (mq.size() != 0));
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act) begin
                if (txd === 1'b0) begin
                    mon_act = 1'b1;
                    mon_cnt = 0;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_act) begin
                if (mon_cnt == C / 2) begin
                    chk("mon_start", txd, 0);
                end else if (mon_cnt == C / 2 + 9 * C) begin
                    chk("mon_stop", txd, 1);
                    rxq.push_back(mon_byte);
                    mon_act = 1'b0;
                end else if (mon_cnt > C / 2 && ((mon_cnt - C / 2) % C) == 0) begin
                    mon_byte[(mon_cnt - C / 2) / C - 1] = txd;
                end
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n;
        for (n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            #3;
            if (!tx_busy && !mon_act) break;
        end
        if (n == max_cyc) begin
            errors++;
            $display("FAIL drain_timeout: busy=%0d mon=%0d after %0d cycles", tx_busy, mon_act, max_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_rx(input string name);
        chk({name, "_len"}, rxq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rxq.size()) chk($sformatf("%s_byte%0d", name, i), rxq[i], exp_q[i]);
        end
        rxq.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] frame;
        int p;
        int k;
        int sent_n;
        logic [7:0] sent[$];

        #1 rst = 1'b1;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_count", tx_count, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: reset in the middle of a frame
        tx_we = 1'b1; tx_data = 8'h55;
        @(negedge clk);
        tx_we = 1'b0;
        repeat (8) @(negedge clk);
        chk("t1_busy_before", tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("t1_txd", txd, 1);
        chk("t1_count", tx_count, 0);
        chk("t1_ready", tx_ready, 1);
        chk("t1_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rxq.delete();

        // 2: single byte, literal frame timing
        frame = 10'b1_1010_0101_0;
        tx_we = 1'b1; tx_data = 8'hA5;
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            if (j == 1) tx_we = 1'b0;
            #2;
            chk($sformatf("t2_txd_%0d", j), txd,
                (j < 2 || j > 41) ? 1'b1 : frame[(j - 2) / C]);
            chk($sformatf("t2_busy_%0d", j), tx_busy, j <= 41);
        end
        wait_drain(200);
        exp_q = '{8'hA5};
        check_rx("t2_rx");

        // 3: three consecutive pushes -> gapless frames
        @(negedge clk);
        tx_we = 1'b1; tx_data = 8'h01;
        @(negedge clk); tx_data = 8'h02;
        @(negedge clk); tx_data = 8'h03;
        @(negedge clk); tx_we = 1'b0;
        for (int j = 4; j <= 122; j++) begin
            @(negedge clk);
            #2;
            if (j == 121) chk("t3_busy_last", tx_busy, 1);
            if (j == 122) chk("t3_busy_end", tx_busy, 0);
        end
        wait_drain(400);
        exp_q = '{8'h01, 8'h02, 8'h03};
        check_rx("t3_rx");

        // 4+5: fill the FIFO behind an active frame, then hold a push across the pop
        @(negedge clk);
        tx_we = 1'b1; tx_data = 8'hEE;
        p = cyc_n;
        @(negedge clk); tx_we = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            tx_we = 1'b1; tx_data = 8'h10 + 8'(b);
            @(negedge clk);
        end
        tx_data = 8'h14;
        #1;
        chk("t4_full_ready", tx_ready, 0);
        chk("t4_full_count", tx_count, 4);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            tx_data = 8'h77;
            #1;
            if (tx_ready) break;
        end
        if (k == 100) begin
            errors++;
            $display("FAIL t5_accept_timeout: tx_ready stayed %0d", tx_ready);
        end else begin
            chk("t5_accept_count", tx_count, 3);
            chk("t5_accept_cycle", cyc_n - p, 42);
        end
        @(negedge clk);
        tx_we = 1'b0;
        wait_drain(600);
        exp_q = '{8'hEE, 8'h10, 8'h11, 8'h12, 8'h13, 8'h77};
        check_rx("t4_rx");

        // 6: stream with handshake, pointers wrap several times
        sent_n = 0;
        for (k = 0; k < 3000 && sent_n < 20; k++) begin
            @(negedge clk);
            if (tx_ready) begin
                tx_we = 1'b1;
                tx_data = 8'($urandom_range(0, 255));
                sent.push_back(tx_data);
                sent_n++;
            end else begin
                tx_we = 1'b0;
            end
        end
        @(negedge clk);
        tx_we = 1'b0;
        if (sent_n != 20) begin
            errors++;
            $display("FAIL t6_push_timeout: pushed %0d of 20", sent_n);
        end
        wait_drain(2000);
        exp_q = sent;
        check_rx("t6_rx");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
